poly_basemul_ctrl: RTL and testbench

- Polynomial-level sequencer and initiator for the existing basemul unit.
- Walks all 128 coefficient pairs of two NTT-domain polynomials (KYBER_N = 256).
- For each pair it:
  - fetches a and b from coefficient RAM;
  - selects the twiddle zeta from an internal ROM;
  - issues one basemul transaction and waits for its valid;
  - writes the product pair back to the result RAM.
- Sits between the polynomial RAMs and basemul inside the NTT/matrix-vector datapath.

---
 rtl/poly_basemul_ctrl_pkg.sv | 40 ++++
 rtl/poly_basemul_ctrl_if.sv | 37 +++
 rtl/poly_basemul_ctrl_zeta_basemul_rom.sv | 32 +++
 rtl/poly_basemul_ctrl.sv | 152 +++++++++++++++
 tb/tb_poly_basemul_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/poly_basemul_ctrl_pkg.sv
// Shared widths, Kyber constants and FSM encoding for the polynomial basemul sequencer.
package poly_basemul_ctrl_pkg;

  localparam int unsigned KYBER_N            = 256;
  localparam int unsigned KYBER_Q            = 3329;
  localparam int unsigned KYBER_POLY_WIDTH   = 16;
  localparam int unsigned PAIR_AW            = 7;
  localparam int unsigned NUM_PAIRS          = KYBER_N / 2;
  localparam int unsigned ZETA_BASEMUL_DEPTH = 64;
  localparam int unsigned ZETA_AW            = $clog2(ZETA_BASEMUL_DEPTH);

  typedef logic [KYBER_POLY_WIDTH-1:0]   coeff_t;
  typedef logic [2*KYBER_POLY_WIDTH-1:0] coeff_pair_t;
  typedef logic [PAIR_AW-1:0]            pair_idx_t;

  localparam coeff_t    KYBER_Q_C = coeff_t'(KYBER_Q);
  localparam pair_idx_t LAST_PAIR = pair_idx_t'(NUM_PAIRS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_WRITE = S_WRITE,
    ST_DONE  = S_DONE
  } state_e;

  // z is never 0, so q - z stays inside [1, q-1].
  function automatic coeff_t zeta_negate(input coeff_t z);
    return KYBER_Q_C - z;
  endfunction

endpackage

// File: rtl/poly_basemul_ctrl_if.sv
// Handshake and data bus between the sequencer, the a/b/result RAMs and basemul.
interface poly_basemul_ctrl_if;
  import poly_basemul_ctrl_pkg::*;

  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  pair_idx_t   rd_addr;
  coeff_pair_t a_rdata;
  coeff_pair_t b_rdata;
  logic        bm_start;
  coeff_t      bm_a0;
  coeff_t      bm_a1;
  coeff_t      bm_b0;
  coeff_t      bm_b1;
  coeff_t      bm_zeta;
  logic        bm_valid;
  coeff_t      bm_r0;
  coeff_t      bm_r1;
  logic        wr_en;
  pair_idx_t   wr_addr;
  coeff_pair_t wr_data;

  modport master (
    input  start, a_rdata, b_rdata, bm_valid, bm_r0, bm_r1,
    output busy, done, rd_en, rd_addr, bm_start, bm_a0, bm_a1, bm_b0, bm_b1,
           bm_zeta, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, a_rdata, b_rdata, bm_valid, bm_r0, bm_r1,
    input  busy, done, rd_en, rd_addr, bm_start, bm_a0, bm_a1, bm_b0, bm_b1,
           bm_zeta, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/poly_basemul_ctrl_zeta_basemul_rom.sv
// Basemul twiddle ROM: Kyber zetas[64..127] mod q, even-indexed entries in slots 0..31
// followed by the odd-indexed entries in slots 32..63.
module zeta_basemul_rom
  import poly_basemul_ctrl_pkg::*;
(
  input  logic [ZETA_AW-1:0] idx,
  output coeff_t             zeta
);

  always_comb begin
    case (idx)
      6'd0:  zeta = 16'd2226;  6'd1:  zeta = 16'd555;   6'd2:  zeta = 16'd2078;  6'd3:  zeta = 16'd1550;
      6'd4:  zeta = 16'd422;   6'd5:  zeta = 16'd177;   6'd6:  zeta = 16'd3038;  6'd7:  zeta = 16'd1574;
      6'd8:  zeta = 16'd3083;  6'd9:  zeta = 16'd1159;  6'd10: zeta = 16'd2552;  6'd11: zeta = 16'd2727;
      6'd12: zeta = 16'd1739;  6'd13: zeta = 16'd2457;  6'd14: zeta = 16'd418;   6'd15: zeta = 16'd3173;
      6'd16: zeta = 16'd817;   6'd17: zeta = 16'd603;   6'd18: zeta = 16'd1322;  6'd19: zeta = 16'd1864;
      6'd20: zeta = 16'd2114;  6'd21: zeta = 16'd1218;  6'd22: zeta = 16'd2455;  6'd23: zeta = 16'd2142;
      6'd24: zeta = 16'd2144;  6'd25: zeta = 16'd2051;  6'd26: zeta = 16'd1819;  6'd27: zeta = 16'd2459;
      6'd28: zeta = 16'd3221;  6'd29: zeta = 16'd996;   6'd30: zeta = 16'd958;   6'd31: zeta = 16'd1522;
      6'd32: zeta = 16'd430;   6'd33: zeta = 16'd843;   6'd34: zeta = 16'd871;   6'd35: zeta = 16'd105;
      6'd36: zeta = 16'd587;   6'd37: zeta = 16'd3094;  6'd38: zeta = 16'd2869;  6'd39: zeta = 16'd1653;
      6'd40: zeta = 16'd778;   6'd41: zeta = 16'd3182;  6'd42: zeta = 16'd1483;  6'd43: zeta = 16'd1119;
      6'd44: zeta = 16'd644;   6'd45: zeta = 16'd349;   6'd46: zeta = 16'd329;   6'd47: zeta = 16'd3254;
      6'd48: zeta = 16'd1097;  6'd49: zeta = 16'd610;   6'd50: zeta = 16'd2044;  6'd51: zeta = 16'd384;
      6'd52: zeta = 16'd3193;  6'd53: zeta = 16'd1994;  6'd54: zeta = 16'd220;   6'd55: zeta = 16'd1670;
      6'd56: zeta = 16'd1799;  6'd57: zeta = 16'd794;   6'd58: zeta = 16'd2475;  6'd59: zeta = 16'd478;
      6'd60: zeta = 16'd3021;  6'd61: zeta = 16'd991;   6'd62: zeta = 16'd1869;  6'd63: zeta = 16'd1628;
      default: zeta = '0;
    endcase
  end

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Walks all 128 coefficient pairs: read a/b, issue one basemul, wait for valid, write back.
module poly_basemul_ctrl
  import poly_basemul_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  poly_basemul_ctrl_if.master bus
);

  state_e      state_q, state_d;
  pair_idx_t   k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_en_q, rd_en_d;
  pair_idx_t   rd_addr_q, rd_addr_d;
  logic        bm_start_q, bm_start_d;
  coeff_t      bm_a0_q, bm_a0_d;
  coeff_t      bm_a1_q, bm_a1_d;
  coeff_t      bm_b0_q, bm_b0_d;
  coeff_t      bm_b1_q, bm_b1_d;
  coeff_t      bm_zeta_q, bm_zeta_d;
  logic        wr_en_q, wr_en_d;
  pair_idx_t   wr_addr_q, wr_addr_d;
  coeff_pair_t wr_data_q, wr_data_d;
  coeff_t      rom_zeta;

  zeta_basemul_rom u_zeta_rom (
    .idx  (k_q[PAIR_AW-1:1]),
    .zeta (rom_zeta)
  );

  // Strobes are computed from the next state so each one is high exactly while its state is.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    bm_start_d = 1'b0;
    bm_a0_d    = bm_a0_q;
    bm_a1_d    = bm_a1_q;
    bm_b0_d    = bm_b0_q;
    bm_b1_d    = bm_b1_q;
    bm_zeta_d  = bm_zeta_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_READ;
          k_d       = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      ST_READ: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        bm_a0_d    = bus.a_rdata[KYBER_POLY_WIDTH-1:0];
        bm_a1_d    = bus.a_rdata[2*KYBER_POLY_WIDTH-1:KYBER_POLY_WIDTH];
        bm_b0_d    = bus.b_rdata[KYBER_POLY_WIDTH-1:0];
        bm_b1_d    = bus.b_rdata[2*KYBER_POLY_WIDTH-1:KYBER_POLY_WIDTH];
        bm_zeta_d  = k_q[0] ? zeta_negate(rom_zeta) : rom_zeta;
        bm_start_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.bm_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = k_q;
          wr_data_d = {bus.bm_r1, bus.bm_r0};
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (k_q == LAST_PAIR) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          k_d       = k_q + 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = k_q + 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      bm_start_q <= 1'b0;
      bm_a0_q    <= '0;
      bm_a1_q    <= '0;
      bm_b0_q    <= '0;
      bm_b1_q    <= '0;
      bm_zeta_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      bm_start_q <= bm_start_d;
      bm_a0_q    <= bm_a0_d;
      bm_a1_q    <= bm_a1_d;
      bm_b0_q    <= bm_b0_d;
      bm_b1_q    <= bm_b1_d;
      bm_zeta_q  <= bm_zeta_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.bm_start = bm_start_q;
  assign bus.bm_a0    = bm_a0_q;
  assign bus.bm_a1    = bm_a1_q;
  assign bus.bm_b0    = bm_b0_q;
  assign bus.bm_b1    = bm_b1_q;
  assign bus.bm_zeta  = bm_zeta_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Directed sequence over randomized RAM contents, checked against a pair-level reference model.
module tb_poly_basemul_ctrl;
  import poly_basemul_ctrl_pkg::*;

  localparam int NPAIRS = 128;
  // Kyber reference zetas[64..127], reduced into [0, q), natural order.
  localparam int ZREF [64] = '{
    2226,  430,  555,  843, 2078,  871, 1550,  105,
     422,  587,  177, 3094, 3038, 2869, 1574, 1653,
    3083,  778, 1159, 3182, 2552, 1483, 2727, 1119,
    1739,  644, 2457,  349,  418,  329, 3173, 3254,
     817, 1097,  603,  610, 1322, 2044, 1864,  384,
    2114, 3193, 1218, 1994, 2455,  220, 2142, 1670,
    2144, 1799, 2051,  794, 1819, 2475, 2459,  478,
    3221, 3021,  996,  991,  958, 1869, 1522, 1628
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int     stub_lat = 3;
  int     stub_cnt = 0;
  logic   stub_valid = 1'b0;
  logic   spur_valid = 1'b0;
  logic   override_k0 = 1'b0;
  coeff_t stub_r0 = '0;
  coeff_t stub_r1 = '0;

  coeff_pair_t a_mem [NPAIRS];
  coeff_pair_t b_mem [NPAIRS];

  int exp_read, exp_issue, exp_write, n_writes;

  poly_basemul_ctrl_if bus_if ();

  poly_basemul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient RAMs: one-cycle read latency, garbage on the bus when not read.
  always @(posedge clk) begin
    if (bus_if.rd_en) begin
      bus_if.a_rdata <= a_mem[bus_if.rd_addr];
      bus_if.b_rdata <= b_mem[bus_if.rd_addr];
    end else begin
      bus_if.a_rdata <= $urandom;
      bus_if.b_rdata <= $urandom;
    end
  end

  // Basemul stub: r = a + b per lane, valid stub_lat cycles after the start pulse.
  always @(posedge clk) begin
    stub_valid <= 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_valid <= 1'b1;
    end
    if (bus_if.bm_start) begin
      stub_cnt <= stub_lat - 1;
      stub_r0  <= override_k0 ? 16'd9 : coeff_t'(bus_if.bm_a0 + bus_if.bm_b0);
      stub_r1  <= override_k0 ? 16'd7 : coeff_t'(bus_if.bm_a1 + bus_if.bm_b1);
    end
  end

  assign bus_if.bm_valid = stub_valid | spur_valid;
  assign bus_if.bm_r0    = stub_r0;
  assign bus_if.bm_r1    = stub_r1;

  function automatic int zeta_ref(input int k);
    int i, z;
    i = k / 2;
    z = (i < 32) ? ZREF[2*i] : ZREF[2*(i-32)+1];
    return (k % 2 == 1) ? (3329 - z) : z;
  endfunction

  function automatic logic [31:0] wdata_ref(input int k);
    coeff_pair_t av, bv;
    logic [15:0] s0, s1;
    if (override_k0 && k == 0) return 32'h0007_0009;
    av = a_mem[k];
    bv = b_mem[k];
    s0 = av[15:0] + bv[15:0];
    s1 = av[31:16] + bv[31:16];
    return {s1, s0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {bus_if.busy, bus_if.done, bus_if.rd_en, bus_if.bm_start, bus_if.wr_en}, 0);
    chk({tag, "_addr"}, {bus_if.rd_addr, bus_if.wr_addr}, 0);
    chk({tag, "_operands"}, {bus_if.bm_a0, bus_if.bm_a1, bus_if.bm_b0, bus_if.bm_b1}, 0);
    chk({tag, "_zeta"}, bus_if.bm_zeta, 0);
    chk({tag, "_wr_data"}, bus_if.wr_data, 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NPAIRS; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = $urandom;
    end
  endtask

  task automatic do_pass(input int lat, input bit inject, input int abort_k, input bit ovr);
    int s_cyc, done_at, budget, fz;
    bit fin, aborted;
    coeff_pair_t av, bv;
    stub_lat = lat;
    override_k0 = ovr;
    exp_read = 0; exp_issue = 0; exp_write = 0; n_writes = 0;
    fin = 1'b0; aborted = 1'b0; done_at = -1;
    budget = NPAIRS * (4 + lat) + 40;
    @(negedge clk);
    bus_if.start = 1'b1;
    s_cyc = cyc;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      spur_valid   = 1'b0;
      if (c == 0) chk("busy_after_start", bus_if.busy, 1);
      if (bus_if.rd_en) begin
        chk("rd_addr", bus_if.rd_addr, exp_read);
        if (inject && exp_read == 10) spur_valid = 1'b1;
        exp_read++;
      end
      if (bus_if.bm_start) begin
        av = a_mem[exp_issue];
        bv = b_mem[exp_issue];
        chk("operands", {bus_if.bm_a1, bus_if.bm_a0, bus_if.bm_b1, bus_if.bm_b0}, {av, bv});
        chk("bm_zeta", bus_if.bm_zeta, zeta_ref(exp_issue));
        if (ovr) begin
          fz = -1;
          case (exp_issue)
            0: fz = 2226;
            1: fz = 1103;
            2: fz = 555;
            3: fz = 2774;
            127: fz = 1701;
            default: fz = -1;
          endcase
          if (fz >= 0) chk("bm_zeta_known", bus_if.bm_zeta, fz);
          if (exp_issue == 0) begin
            chk("pair0_a", {bus_if.bm_a1, bus_if.bm_a0}, {16'd59894, 16'd50360});
            chk("pair0_b", {bus_if.bm_b1, bus_if.bm_b0}, {16'd35686, 16'd21906});
          end
        end
        if (inject && exp_issue == 20) bus_if.start = 1'b1;
        if (exp_issue == abort_k) begin
          rst = 1'b1;
          aborted = 1'b1;
          fin = 1'b1;
        end
        exp_issue++;
      end
      if (bus_if.wr_en) begin
        chk("wr_addr", bus_if.wr_addr, exp_write);
        chk("wr_data", bus_if.wr_data, wdata_ref(exp_write));
        if (exp_write == 0) override_k0 = 1'b0;
        exp_write++;
        n_writes++;
      end
      if (bus_if.done) begin
        fin = 1'b1;
        done_at = cyc;
        chk("busy_at_done", bus_if.busy, 0);
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("abort");
      chk("abort_writes", n_writes, abort_k);
      repeat (8) begin
        @(negedge clk);
        chk("abort_no_write", bus_if.wr_en, 0);
        chk("abort_idle", {bus_if.busy, bus_if.rd_en}, 0);
      end
    end else begin
      chk("done_seen", fin, 1);
      chk("done_cycle", done_at - s_cyc, NPAIRS * (4 + lat) + 1);
      chk("write_count", n_writes, NPAIRS);
      repeat (3) begin
        @(negedge clk);
        chk("done_once", bus_if.done, 0);
        chk("post_idle", {bus_if.busy, bus_if.wr_en, bus_if.rd_en}, 0);
      end
    end
  endtask

  initial begin
    bus_if.start = 1'b1;
    rst = 1'b1;
    fill_mem();
    a_mem[0] = {16'd59894, 16'd50360};
    b_mem[0] = {16'd35686, 16'd21906};

    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    rst = 1'b0;
    bus_if.start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {bus_if.busy, bus_if.rd_en}, 0);

    do_pass(3, 1'b0, -1, 1'b1);
    fill_mem();
    do_pass(3, 1'b1, -1, 1'b0);
    fill_mem();
    do_pass(5, 1'b0, -1, 1'b0);
    fill_mem();
    do_pass(3, 1'b0, 40, 1'b0);
    do_pass(3, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
